// File: rtl/half_fp_add_arbiter_if.sv
// Bundle for half_fp_add_arbiter: requester ports, adder start/done port, tagged response port.
// slave = arbiter side, master = environment side (clients, adder, response sink).
interface half_fp_add_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic                  add_start;
  logic [15:0]           add_a;
  logic [15:0]           add_b;
  logic                  add_done;
  logic [15:0]           add_sum;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [15:0]           resp_sum;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, add_done, add_sum, resp_ready,
    output req_ready, add_start, add_a, add_b, resp_valid, resp_id, resp_sum, busy
  );

  modport master (
    output req_valid, req_a, req_b, add_done, add_sum, resp_ready,
    input  req_ready, add_start, add_a, add_b, resp_valid, resp_id, resp_sum, busy
  );
endinterface

// File: rtl/half_fp_add_arbiter.sv
// Round-robin front end sharing one multi-cycle half-precision adder among NUM_REQ clients.
// Optional macro HFP_ARB_ZERO_BYPASS_EN: answer +/-0 operand pairs directly without the adder.
module half_fp_add_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  half_fp_add_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [15:0]     a_q, a_d;
  logic [15:0]     b_q, b_d;
  logic [15:0]     sum_q, sum_d;

  logic            found;
  logic [ID_W-1:0] grant_id;
  logic [15:0]     win_a, win_b;

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    found    = 1'b0;
    grant_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found    = 1'b1;
        grant_id = ID_W'(idx);
      end
    end
  end

  assign win_a = bus.req_a[16*grant_id +: 16];
  assign win_b = bus.req_b[16*grant_id +: 16];

  always_comb begin
    bus.req_ready = '0;
    if (state_q == S_IDLE && found && !rst) bus.req_ready[grant_id] = 1'b1;
  end

`ifdef HFP_ARB_ZERO_BYPASS_EN
  logic        zero_a, zero_b;
  logic [15:0] byp_sum;
  always_comb begin
    zero_a = (win_a[14:0] == 15'd0);
    zero_b = (win_b[14:0] == 15'd0);
    if (zero_a && zero_b) byp_sum = {win_a[15] & win_b[15], 15'd0};
    else if (zero_b)      byp_sum = win_a;
    else                  byp_sum = win_b;
  end
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          a_d      = win_a;
          b_d      = win_b;
          id_d     = grant_id;
          rr_ptr_d = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
`ifdef HFP_ARB_ZERO_BYPASS_EN
          if (zero_a || zero_b) begin
            sum_d   = byp_sum;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d  = S_ISSUE;
`endif
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.add_done) begin
          sum_d   = bus.add_sum;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
    end
  end

  assign bus.add_start  = (state_q == S_ISSUE);
  assign bus.add_a      = a_q;
  assign bus.add_b      = b_q;
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_id    = id_q;
  assign bus.resp_sum   = sum_q;
  assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_half_fp_add_arbiter.sv
// Directed bench for half_fp_add_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_half_fp_add_arbiter;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  half_fp_add_arbiter_if #(.NUM_REQ(4)) bus ();

  half_fp_add_arbiter #(.NUM_REQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef HFP_ARB_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [15:0] op_a [4];
  logic [15:0] op_b [4];
  always_comb begin
    bus.req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    bus.req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
  end

  // Adder stand-in: fixed table of IEEE half sums, LAT cycles from start to done.
  function automatic logic [15:0] stub_add(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_4000: return 16'h4200;
      32'h3C00_3C00: return 16'h4000;
      32'h4000_4000: return 16'h4400;
      32'h8000_8000: return 16'h8000;
      32'h4500_0000: return 16'h4500;
      32'h0000_C200: return 16'hC200;
      32'h8000_0000: return 16'h0000;
      32'h3C00_BC00: return 16'h0000;
      default:       return a ^ b;
    endcase
  endfunction

  logic        model_done = 1'b0;
  logic [15:0] model_sum = '0;
  int          model_cnt = 0;
  logic        spur_done;
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (bus.add_start) begin
      model_cnt <= LAT - 1;
      model_sum <= stub_add(bus.add_a, bus.add_b);
    end else if (model_cnt > 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) model_done <= 1'b1;
    end
  end
  assign bus.add_done = model_done | spur_done;
  assign bus.add_sum  = spur_done ? 16'hBEEF : model_sum;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Present vmask, complete one operation, accept the response immediately.
  task automatic run_op(input logic [3:0] vmask, input bit drop_after, output int gid,
                        output logic [1:0] rid, output logic [15:0] sum, output int lat,
                        output bit started);
    int n;
    gid = -1; rid = '0; sum = '0; lat = 0; started = 1'b0;
    bus.req_valid = vmask;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin step(); n++; end
    for (int i = 0; i < 4; i++) if (bus.req_ready[i]) gid = i;
    check("grant_seen", {31'd0, bus.req_ready != '0}, 32'd1);
    do begin
      step();
      if (drop_after) bus.req_valid = '0;
      lat++;
      started |= bus.add_start;
    end while (!bus.resp_valid && lat < 30);
    check("resp_timeout", {31'd0, bus.resp_valid}, 32'd1);
    rid = bus.resp_id;
    sum = bus.resp_sum;
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("idle_after_resp", {30'd0, bus.busy, bus.resp_valid}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_sum;
    bit          zero_op;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          gid, lat, n;
    logic [1:0]  rid;
    logic [15:0] sum;
    bit          started, seen;

    vecs[0] = '{2'd0, 16'h3C00, 16'h3C00, 16'h4000, 1'b0};
    vecs[1] = '{2'd1, 16'h4000, 16'h4000, 16'h4400, 1'b0};
    vecs[2] = '{2'd3, 16'h8000, 16'h8000, 16'h8000, 1'b1};
    vecs[3] = '{2'd2, 16'h4500, 16'h0000, 16'h4500, 1'b1};
    vecs[4] = '{2'd1, 16'h0000, 16'hC200, 16'hC200, 1'b1};
    vecs[5] = '{2'd0, 16'h8000, 16'h0000, 16'h0000, 1'b1};
    vecs[6] = '{2'd3, 16'h3C00, 16'hBC00, 16'h0000, 1'b0};

    for (int i = 0; i < 4; i++) begin op_a[i] = '0; op_b[i] = '0; end
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.resp_ready = 1'b0;
    spur_done = 1'b0;
    #1;
    check("rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
    check("rst_outputs", {bus.add_start, bus.resp_valid, bus.busy, bus.resp_id}, 32'd0);
    check("rst_data", {bus.resp_sum, bus.add_a}, 32'd0);
    bus.req_valid = '0;
    step(); step();
    rst = 1'b0;

    // Single request from requester 2 with exact cycle timing.
    op_a[2] = 16'h3C00; op_b[2] = 16'h4000;
    bus.req_valid = 4'b0100;
    #1;
    check("single_ready", {28'd0, bus.req_ready}, 32'h4);
    step();
    bus.req_valid = '0;
    check("single_issue", {29'd0, bus.add_start, bus.busy, bus.req_ready != '0}, 32'b110);
    check("single_operands", {bus.add_a, bus.add_b}, 32'h3C00_4000);
    step();
    check("single_start_one_cycle", {31'd0, bus.add_start}, 32'd0);
    n = 2;
    while (!bus.resp_valid && n < 30) begin step(); n++; end
    check("single_latency", n, 32'd6);
    check("single_id", {30'd0, bus.resp_id}, 32'd2);
    check("single_sum", {16'd0, bus.resp_sum}, 32'h4200);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("single_busy_low", {31'd0, bus.busy}, 32'd0);

    // Table: single requester each, so the grant is that requester regardless of rr_ptr.
    foreach (vecs[v]) begin
      op_a[vecs[v].id] = vecs[v].a;
      op_b[vecs[v].id] = vecs[v].b;
      run_op(4'b0001 << vecs[v].id, 1'b1, gid, rid, sum, lat, started);
      check($sformatf("vec%0d_grant", v), gid, {30'd0, vecs[v].id});
      check($sformatf("vec%0d_id", v), {30'd0, rid}, {30'd0, vecs[v].id});
      check($sformatf("vec%0d_sum", v), {16'd0, sum}, {16'd0, vecs[v].exp_sum});
      check($sformatf("vec%0d_latency", v), lat, (BYP && vecs[v].zero_op) ? 32'd1 : 32'd6);
      check($sformatf("vec%0d_start", v), {31'd0, started},
            (BYP && vecs[v].zero_op) ? 32'd0 : 32'd1);
    end

    // Reset while waiting on the adder; the late add_done must be dropped.
    op_a[0] = 16'h4000; op_b[0] = 16'h4000;
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    step(); step();
    check("wait_busy", {31'd0, bus.busy}, 32'd1);
    bus.req_valid = 4'hF;
    rst = 1'b1;
    #1;
    check("midrst_outputs", {28'd0, bus.resp_valid, bus.busy, bus.add_start, bus.req_ready != '0}, 32'd0);
    check("midrst_data", {bus.resp_sum, bus.add_b}, 32'd0);
    bus.req_valid = '0;
    step(); step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); seen |= bus.resp_valid | bus.busy; end
    check("late_done_ignored", {31'd0, seen}, 32'd0);

    // All requesters valid: 0,1,2,3,0 proves rr_ptr restarted at 0 and wraps.
    for (int i = 0; i < 4; i++) begin op_a[i] = 16'h3C00; op_b[i] = 16'h4000; end
    for (int g = 0; g < 5; g++) begin
      run_op(4'hF, 1'b0, gid, rid, sum, lat, started);
      check($sformatf("rr_grant%0d", g), gid, g % 4);
      check($sformatf("rr_id%0d", g), {30'd0, rid}, g % 4);
    end
    bus.req_valid = '0;

    // Requester 1 drops before handshake; requester 3 wins (rr_ptr is 1 here).
    bus.req_valid = 4'b1010;
    #1;
    check("drop_offer1", {28'd0, bus.req_ready}, 32'h2);
    bus.req_valid = 4'b1000;
    #1;
    check("drop_offer3", {28'd0, bus.req_ready}, 32'h8);
    run_op(4'b1000, 1'b1, gid, rid, sum, lat, started);
    check("drop_grant", gid, 32'd3);
    check("drop_id", {30'd0, rid}, 32'd3);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin step(); seen |= bus.resp_valid; end
    check("drop_no_resp1", {31'd0, seen}, 32'd0);

    // Backpressure: 5 stalled RESP cycles, other requesters pending, spurious done pulses.
    op_a[1] = 16'h3C00; op_b[1] = 16'h3C00;
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    n = 0;
    while (!bus.resp_valid && n < 30) begin step(); n++; end
    check("bp_resp", {31'd0, bus.resp_valid}, 32'd1);
    bus.req_valid = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      spur_done = i[0];
      step();
      if (!bus.resp_valid || bus.resp_id != 2'd1 || bus.resp_sum != 16'h4000 ||
          bus.req_ready != '0) seen = 1'b1;
    end
    spur_done = 1'b0;
    check("bp_stable", {31'd0, seen}, 32'd0);
    check("bp_sum", {16'd0, bus.resp_sum}, 32'h4000);
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("bp_release", {30'd0, bus.busy, bus.resp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
